pipelined_addsub: RTL and testbench

- Parametrised, pipelined N-bit adder/subtractor; the successor to the combinational ripple-carry adder.
- Operand width is split into STAGES equal chunks; each pipeline stage resolves one chunk and forwards its carry to the next stage.
- Result carries signed-overflow and zero flags.
- Valid/ready handshakes on input and output; one operation accepted per cycle; full backpressure support.
- Used by datapath blocks that need wide add/sub at clock rates a full ripple chain cannot meet.

---
 rtl/pipelined_addsub_if.sv | 28 ++
 rtl/pipelined_addsub.sv | 113 +++++++++++
 tb/tb_pipelined_addsub.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Handshake and operand/result bundle for the pipelined adder/subtractor.
// The master drives operands and consumes results; the slave is the adder.
interface pipelined_addsub_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
    logic             Zero;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf, Zero
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf, Zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: stage k resolves chunk k and hands its
// carry forward, with an elastic valid/ready chain that stalls in place.
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              resetN,
    pipelined_addsub_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    // r_acc[k]: resolved sum in chunks 0..k, untouched A bits above that
    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_acc [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [STAGES-1:0] r_c;
    logic              r_ovf;
    logic              r_zero;

    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;
    logic              w_in_ready;
    logic [WIDTH-1:0]  w_acc_in  [STAGES];
    logic [WIDTH-1:0]  w_b_in    [STAGES];
    logic [STAGES-1:0] w_c_in;
    logic [CHUNK:0]    w_ext     [STAGES];
    logic [WIDTH-1:0]  w_acc_nxt [STAGES];
    logic              w_c_msb;
    logic              w_unused;

    always_comb begin
        logic [STAGES-1:0] adv;
        adv             = '0;
        adv[STAGES-1]   = r_v[STAGES-1] & bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = r_v[k] & (~r_v[k+1] | adv[k+1]);
        end
        w_adv      = adv;
        w_in_ready = ~r_v[0] | adv[0];
        w_load     = '0;
        w_load[0]  = bus.in_valid & w_in_ready;
        for (int k = 1; k < STAGES; k++) begin
            w_load[k] = adv[k-1];
        end
    end

    always_comb begin
        w_acc_in[0] = bus.A;
        w_b_in[0]   = bus.sub ? ~bus.B : bus.B;
        w_c_in      = '0;
        w_c_in[0]   = bus.sub ? 1'b1 : bus.Cin;
        for (int k = 1; k < STAGES; k++) begin
            w_acc_in[k] = r_acc[k-1];
            w_b_in[k]   = r_b[k-1];
            w_c_in[k]   = r_c[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_ext[k] = {1'b0, w_acc_in[k][k*CHUNK +: CHUNK]}
                     + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, w_c_in[k]};
            w_acc_nxt[k]                    = w_acc_in[k];
            w_acc_nxt[k][k*CHUNK +: CHUNK]  = w_ext[k][CHUNK-1:0];
        end
        // carry into the MSB recovered from the MSB's own sum and operands
        w_c_msb = w_ext[STAGES-1][CHUNK-1]
                ^ w_acc_in[STAGES-1][WIDTH-1]
                ^ w_b_in[STAGES-1][WIDTH-1];
    end

    // consumed low chunks of the B pipeline are dead after their stage
    always_comb begin
        w_unused = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_unused = w_unused ^ (^r_b[k]);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_v    <= '0;
            r_c    <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_acc[k] <= '0;
                r_b[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k]   <= 1'b1;
                    r_acc[k] <= w_acc_nxt[k];
                    r_b[k]   <= w_b_in[k];
                    r_c[k]   <= w_ext[k][CHUNK];
                end else if (w_adv[k]) begin
                    r_v[k] <= 1'b0;
                end
            end
            if (w_load[STAGES-1]) begin
                r_ovf  <= w_c_msb ^ w_ext[STAGES-1][CHUNK];
                r_zero <= (w_acc_nxt[STAGES-1] == '0);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_v[STAGES-1];
    assign bus.S         = r_acc[STAGES-1];
    assign bus.Cout      = r_c[STAGES-1];
    assign bus.Ovf       = r_ovf;
    assign bus.Zero      = r_zero;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed cases on a 64/4 instance plus a random
// sweep of several width/depth configurations against an arithmetic model.
module tb_pipelined_addsub;
    localparam int W       = 64;
    localparam int ST      = 4;
    localparam int N_SWEEP = 10000;

    typedef struct packed {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(W)) m_if ();
    pipelined_addsub #(.WIDTH(W), .STAGES(ST)) u_dut (
        .clk    (clk),
        .resetN (rst_n),
        .bus    (m_if.slave)
    );

    logic [63:0] sw_a [4];
    logic [63:0] sw_b [4];
    logic [63:0] sw_s [4];
    logic sw_cin [4], sw_sub [4], sw_iv [4], sw_or [4];
    logic sw_ir [4], sw_ov [4], sw_cout [4], sw_ovf [4], sw_zero [4];
    int   sw_w [4] = '{8, 16, 64, 64};

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int GW = (g == 0) ? 8 : (g == 1) ? 16 : 64;
        localparam int GS = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 64;
        pipelined_addsub_if #(.WIDTH(GW)) sif ();
        pipelined_addsub #(.WIDTH(GW), .STAGES(GS)) u_sw (
            .clk    (clk),
            .resetN (rst_n),
            .bus    (sif.slave)
        );
        assign sif.in_valid  = sw_iv[g];
        assign sif.A         = sw_a[g][GW-1:0];
        assign sif.B         = sw_b[g][GW-1:0];
        assign sif.Cin       = sw_cin[g];
        assign sif.sub       = sw_sub[g];
        assign sif.out_ready = sw_or[g];
        assign sw_ir[g]      = sif.in_ready;
        assign sw_ov[g]      = sif.out_valid;
        assign sw_s[g]       = 64'(sif.S);
        assign sw_cout[g]    = sif.Cout;
        assign sw_ovf[g]     = sif.Ovf;
        assign sw_zero[g]    = sif.Zero;
    end

    // Reference: plain modular arithmetic, unsigned borrow and signed range rules
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic op_sub);
        logic [64:0] m, aa, bb, full;
        res_t r;
        m  = (65'd1 << w) - 65'd1;
        aa = {1'b0, a} & m;
        bb = {1'b0, b} & m;
        if (op_sub) begin
            full   = (aa - bb) & m;
            r.cout = (aa >= bb);
            r.ovf  = (aa[w-1] != bb[w-1]) && (full[w-1] != aa[w-1]);
        end else begin
            full   = aa + bb + 65'(cin);
            r.cout = full[w];
            full   = full & m;
            r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        end
        r.s    = full[63:0];
        r.zero = (full == 65'd0);
        return r;
    endfunction

    task automatic run_single(input logic [63:0] a, input logic [63:0] b, input logic cin,
                              input logic op_sub, output res_t r, output int lat);
        m_if.A         = a;
        m_if.B         = b;
        m_if.Cin       = cin;
        m_if.sub       = op_sub;
        m_if.in_valid  = 1'b1;
        m_if.out_ready = 1'b1;
        r   = '0;
        lat = -1;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (m_if.out_valid) begin
                lat = i;
                r   = '{s: m_if.S, cout: m_if.Cout, ovf: m_if.Ovf, zero: m_if.Zero};
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        m_if.in_valid  = 1'b1;
        m_if.A         = 64'h1234;
        m_if.B         = 64'h1;
        m_if.Cin       = 1'b0;
        m_if.sub       = 1'b0;
        m_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (m_if.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", m_if.out_valid);
        else n_pass++;
        n_checks++;
        if (m_if.S !== 64'h0) $display("FAIL reset_S: got %h expected 0", m_if.S);
        else n_pass++;
        n_checks++;
        if ({m_if.Cout, m_if.Ovf, m_if.Zero} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {m_if.Cout, m_if.Ovf, m_if.Zero});
        else n_pass++;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        rst_n         = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_if.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", m_if.in_ready);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_add_carry();
        res_t r;
        int   lat;
        run_single(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, r, lat);
        n_checks++;
        if (lat !== ST) $display("FAIL add_carry_latency: got %0d expected %0d", lat, ST);
        else n_pass++;
        n_checks++;
        if (r.s !== 64'h0) $display("FAIL add_carry_S: got %h expected 0", r.s);
        else n_pass++;
        n_checks++;
        if ({r.cout, r.ovf, r.zero} !== 3'b101)
            $display("FAIL add_carry_flags(cout,ovf,zero): got %b expected 101", {r.cout, r.ovf, r.zero});
        else n_pass++;
    endtask

    task automatic test_subtract();
        res_t r;
        int   lat;
        run_single(64'd5, 64'd7, 1'b1, 1'b1, r, lat);
        n_checks++;
        if (r.s !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL sub_5_7_S: got %h expected fffffffffffffffe", r.s);
        else n_pass++;
        n_checks++;
        if ({r.cout, r.ovf, r.zero} !== 3'b000)
            $display("FAIL sub_5_7_flags(cout,ovf,zero): got %b expected 000", {r.cout, r.ovf, r.zero});
        else n_pass++;
        run_single(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, r, lat);
        n_checks++;
        if (r.s !== 64'h7FFF_FFFF_FFFF_FFFF) $display("FAIL sub_min_1_S: got %h expected 7fffffffffffffff", r.s);
        else n_pass++;
        n_checks++;
        if ({r.cout, r.ovf, r.zero} !== 3'b110)
            $display("FAIL sub_min_1_flags(cout,ovf,zero): got %b expected 110", {r.cout, r.ovf, r.zero});
        else n_pass++;
        n_checks++;
        if (lat !== ST) $display("FAIL sub_latency: got %0d expected %0d", lat, ST);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        logic [63:0] s_prev = '0;
        logic        stall_prev = 1'b0;
        logic        in_x, out_x;
        int          sent = 0, got = 0, cnt = 0, cyc = 0;
        m_if.sub       = 1'b0;
        m_if.Cin       = 1'b0;
        m_if.A         = 64'd1;
        m_if.B         = 64'd2;
        m_if.in_valid  = 1'b1;
        m_if.out_ready = 1'b1;
        while (got < 10 && cyc < 200) begin
            @(negedge clk);
            if (stall_prev) begin
                n_checks++;
                if (m_if.out_valid !== 1'b1 || m_if.S !== s_prev)
                    $display("FAIL b2b_stall_stable cyc=%0d: got v=%b S=%h expected v=1 S=%h",
                             cyc, m_if.out_valid, m_if.S, s_prev);
                else n_pass++;
            end
            n_checks++;
            if (m_if.in_ready !== !(cnt == ST && !m_if.out_ready))
                $display("FAIL b2b_in_ready cyc=%0d: got %b expected %b", cyc, m_if.in_ready,
                         !(cnt == ST && !m_if.out_ready));
            else n_pass++;
            in_x  = m_if.in_valid & m_if.in_ready;
            out_x = m_if.out_valid & m_if.out_ready;
            if (out_x) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra_result: got %h expected none", m_if.S);
                else if (m_if.S !== exp_q[0]) $display("FAIL b2b_result: got %h expected %h", m_if.S, exp_q[0]);
                else n_pass++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            stall_prev = m_if.out_valid & ~m_if.out_ready;
            s_prev     = m_if.S;
            if (in_x) begin
                exp_q.push_back(64'(3 * (sent + 1)));
                sent++;
            end
            cnt = cnt + int'(in_x) - int'(out_x);
            cyc++;
            @(posedge clk); #1;
            m_if.in_valid  = (sent < 10);
            m_if.A         = 64'(sent + 1);
            m_if.B         = 64'(2 * (sent + 1));
            m_if.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        end
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        n_checks++;
        if (got !== 10 || exp_q.size() != 0)
            $display("FAIL b2b_count: got %0d results expected 10 (pending %0d)", got, exp_q.size());
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        res_t r;
        int   lat;
        logic seen = 1'b0;
        m_if.out_ready = 1'b1;
        m_if.sub       = 1'b0;
        m_if.Cin       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_if.A        = 64'(i + 10);
            m_if.B        = 64'd5;
            m_if.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        m_if.in_valid = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (m_if.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL mid_reset_flush: got out_valid=1 expected no result");
        else n_pass++;
        run_single(64'd1, 64'd1, 1'b0, 1'b0, r, lat);
        n_checks++;
        if (r.s !== 64'd2) $display("FAIL mid_reset_S: got %h expected 2", r.s);
        else n_pass++;
        n_checks++;
        if (lat !== ST) $display("FAIL mid_reset_latency: got %0d expected %0d", lat, ST);
        else n_pass++;
    endtask

    task automatic test_sweep();
        res_t        sb [4][$];
        int          acc [4], dlv [4];
        logic        take [4], held [4];
        logic [63:0] held_s [4];
        res_t        got_r, exp_r;
        logic        done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            acc[c] = 0; dlv[c] = 0; take[c] = 1'b0; held[c] = 1'b0; held_s[c] = '0;
            sw_iv[c] = 1'b0;
        end
        for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if (!sw_iv[c] || take[c]) begin
                    sw_iv[c]  = (acc[c] < N_SWEEP) && ($urandom_range(0, 3) != 0);
                    sw_a[c]   = {$urandom(), $urandom()};
                    sw_b[c]   = {$urandom(), $urandom()};
                    case ($urandom_range(0, 7))
                        0: sw_a[c] = '1;
                        1: sw_a[c] = 64'h1 << (sw_w[c] - 1);
                        2: sw_b[c] = sw_a[c];
                        default: ;
                    endcase
                    sw_cin[c] = 1'($urandom_range(0, 1));
                    sw_sub[c] = 1'($urandom_range(0, 1));
                end
                sw_or[c] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            done = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (held[c]) begin
                    n_checks++;
                    if (sw_ov[c] !== 1'b1 || sw_s[c] !== held_s[c])
                        $display("FAIL sweep%0d_stall_stable: got v=%b S=%h expected v=1 S=%h",
                                 c, sw_ov[c], sw_s[c], held_s[c]);
                    else n_pass++;
                end
                if (sw_ov[c] && sw_or[c]) begin
                    got_r = '{s: sw_s[c], cout: sw_cout[c], ovf: sw_ovf[c], zero: sw_zero[c]};
                    n_checks++;
                    if (sb[c].size() == 0) begin
                        $display("FAIL sweep%0d_extra_result: got %h expected none", c, got_r);
                    end else begin
                        exp_r = sb[c].pop_front();
                        if (got_r !== exp_r)
                            $display("FAIL sweep%0d_result: got S=%h c=%b o=%b z=%b expected S=%h c=%b o=%b z=%b",
                                     c, got_r.s, got_r.cout, got_r.ovf, got_r.zero,
                                     exp_r.s, exp_r.cout, exp_r.ovf, exp_r.zero);
                        else n_pass++;
                    end
                    dlv[c]++;
                end
                held[c]   = sw_ov[c] & ~sw_or[c];
                held_s[c] = sw_s[c];
                take[c]   = sw_iv[c] & sw_ir[c];
                if (take[c]) begin
                    sb[c].push_back(model(sw_w[c], sw_a[c], sw_b[c], sw_cin[c], sw_sub[c]));
                    acc[c]++;
                end
                if (dlv[c] < N_SWEEP) done = 1'b0;
            end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 4; c++) begin
            sw_iv[c] = 1'b0;
            sw_or[c] = 1'b1;
            n_checks++;
            if (dlv[c] != N_SWEEP || sb[c].size() != 0)
                $display("FAIL sweep%0d_count: got %0d results expected %0d (pending %0d)",
                         c, dlv[c], N_SWEEP, sb[c].size());
            else n_pass++;
        end
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            sw_iv[c] = 1'b0; sw_or[c] = 1'b1; sw_a[c] = '0; sw_b[c] = '0;
            sw_cin[c] = 1'b0; sw_sub[c] = 1'b0;
        end
        test_reset();
        test_add_carry();
        test_subtract();
        test_back_to_back();
        test_mid_reset();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
